// File: rtl/peripheral_port_arbiter.sv
// Round-robin arbiter that merges N_SRC Hermes flit streams onto one PE port and holds a grant for a whole packet.
// Flit path is combinational (zero latency); PE-port credit is steered back to the owning source only.
module peripheral_port_arbiter #(
  parameter int N_SRC     = 2,
  parameter int FLIT_SIZE = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_SRC-1:0]           src_en_i,
  input  logic [N_SRC-1:0]           src_rx_i,
  output logic [N_SRC-1:0]           src_credit_o,
  input  logic [N_SRC*FLIT_SIZE-1:0] src_data_i,
  output logic                       noc_tx_o,
  input  logic                       noc_credit_i,
  output logic [FLIT_SIZE-1:0]       noc_data_o,
  output logic [$clog2(N_SRC)-1:0]   grant_o,
  output logic                       busy_o
);

  localparam int GW = $clog2(N_SRC);

  typedef enum logic [1:0] {IDLE, HEADER, SIZE, PAYLOAD} state_e;

  state_e               state_q;
  logic [GW-1:0]        grant_q;
  logic [GW-1:0]        rr_ptr_q;
  logic [FLIT_SIZE-1:0] cnt_q;

  logic [GW-1:0]        grant_d;
  logic [GW-1:0]        rr_ptr_d;
  logic                 pick_vld;
  logic [GW:0]          scan_idx;
  logic [FLIT_SIZE-1:0] src_flit [N_SRC];
  logic                 owned;
  logic                 xfer;

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      src_flit[i] = src_data_i[i*FLIT_SIZE +: FLIT_SIZE];
    end
  end

  // Scan downward so the candidate closest to rr_ptr_q is the last one written.
  always_comb begin
    grant_d  = '0;
    pick_vld = 1'b0;
    scan_idx = '0;
    for (int k = N_SRC-1; k >= 0; k--) begin
      scan_idx = {1'b0, rr_ptr_q} + (GW+1)'(k);
      if (scan_idx >= (GW+1)'(N_SRC)) begin
        scan_idx = scan_idx - (GW+1)'(N_SRC);
      end
      if (src_rx_i[scan_idx[GW-1:0]] && src_en_i[scan_idx[GW-1:0]]) begin
        grant_d  = scan_idx[GW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  assign rr_ptr_d = (grant_q == GW'(N_SRC-1)) ? '0 : grant_q + GW'(1);
  assign owned    = (state_q != IDLE);

  always_comb begin
    noc_tx_o     = 1'b0;
    noc_data_o   = '0;
    src_credit_o = '0;
    if (owned) begin
      noc_tx_o              = src_rx_i[grant_q];
      noc_data_o            = src_flit[grant_q];
      src_credit_o[grant_q] = noc_credit_i;
    end
  end

  assign xfer    = noc_tx_o & noc_credit_i;
  assign busy_o  = owned;
  assign grant_o = grant_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q <= grant_d;
            state_q <= HEADER;
          end
        end
        HEADER: begin
          if (xfer) state_q <= SIZE;
        end
        SIZE: begin
          if (xfer) begin
            cnt_q <= noc_data_o;
            if (noc_data_o == '0) begin
              state_q  <= IDLE;
              rr_ptr_q <= rr_ptr_d;
            end else begin
              state_q <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          // Counter is at least 1 here, so the decrement cannot wrap.
          if (xfer) begin
            cnt_q <= cnt_q - FLIT_SIZE'(1);
            if (cnt_q == FLIT_SIZE'(1)) begin
              state_q  <= IDLE;
              rr_ptr_q <= rr_ptr_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/peripheral_port_arbiter.md
PERIPHERAL_PORT_ARBITER -- requirements
Module: peripheral_port_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 2: number of Hermes source streams sharing one PE boundary port (2..8).
REQ-002 SHALL have parameter FLIT_SIZE, default 32: flit width in bits.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port src_en_i, input, N_SRC bits: per-source enable; a disabled source is never granted.
REQ-006 SHALL have port src_rx_i, input, N_SRC bits: per-source flit valid.
REQ-007 SHALL have port src_credit_o, output, N_SRC bits: per-source flit accepted.
REQ-008 SHALL have port src_data_i, input, N_SRC x FLIT_SIZE bits: per-source flit data.
REQ-009 SHALL have port noc_tx_o, output, 1 bit: flit valid toward the PE port.
REQ-010 SHALL have port noc_credit_i, input, 1 bit: PE port can accept a flit.
REQ-011 SHALL have port noc_data_o, output, FLIT_SIZE bits: flit data toward the PE port.
REQ-012 SHALL have port grant_o, output, $clog2(N_SRC) bits: index of the current owner.
REQ-013 SHALL have port busy_o, output, 1 bit: high while a packet is owned (state not IDLE).

Function
REQ-014 SHALL treat a transfer as occurring on any cycle where noc_tx_o and noc_credit_i are both high.
REQ-015 SHALL parse Hermes packets as: flit 0 header, flit 1 payload size S (unsigned, full flit), then S payload flits.
REQ-016 SHALL implement states IDLE, HEADER, SIZE, PAYLOAD.
REQ-017 In IDLE, SHALL select the first source i with src_rx_i[i] and src_en_i[i], searching round-robin from rr_ptr upward with wrap-around; register grant, go to HEADER next cycle; stay in IDLE when there is no eligible request.
REQ-018 In IDLE, noc_tx_o and every src_credit_o bit SHALL be 0; no flit is forwarded.
REQ-019 In HEADER/SIZE/PAYLOAD, noc_tx_o = src_rx_i[grant], noc_data_o = src_data_i[grant], src_credit_o[grant] = noc_credit_i, all other src_credit_o bits 0; all combinational, zero added latency.
REQ-020 HEADER: on transfer, go to SIZE.
REQ-021 SIZE: on transfer, load counter with the size flit value; if 0, go to IDLE, else go to PAYLOAD.
REQ-022 PAYLOAD: each transfer decrements the counter by 1; the transfer with counter==1 ends the packet and returns to IDLE.
REQ-023 On every packet end, SHALL set rr_ptr = grant+1, wrapping to 0 after N_SRC-1.
REQ-024 The counter SHALL be FLIT_SIZE bits wide and never underflow; size 2^FLIT_SIZE-1 SHALL be handled.
REQ-025 Grant SHALL NOT change mid-packet; dropping src_en_i or src_rx_i of the owner stalls but does not abort the packet.
REQ-026 With no transfer in a cycle, state, counter and grant SHALL hold.
REQ-027 Minimum arbitration gap: exactly one IDLE cycle between consecutive packets.
REQ-028 noc_data_o in IDLE SHALL be 0.

Reset
REQ-029 While rst_i is high at a clock edge: state IDLE, grant_o 0, rr_ptr 0, counter 0, busy_o 0, noc_tx_o 0, src_credit_o all 0.
REQ-030 Reset mid-packet SHALL abandon the packet; no partial flit is forwarded after the reset edge.

Verification
REQ-031 Single packet: src0 sends header 0x0102, size 3, payload A,B,C; noc_credit_i=1 -> 5 flits appear in order on noc_data_o, grant_o=0, busy_o falls after C.
REQ-032 Contention: src0 and src1 both request with size 2 -> src0 packet complete (4 flits), one IDLE cycle, then src1 packet; no interleaving.
REQ-033 Fairness: both sources continuously request with size 1 -> grant_o alternates 0,1,0,1 over 4 packets.
REQ-034 Back-pressure: noc_credit_i toggles 1,0,1,0 during a size-4 packet -> no flit lost or duplicated; src_credit_o[grant] mirrors noc_credit_i.
REQ-035 Zero size and enable: size 0 packet -> returns to IDLE after 2 flits; src_en_i[1]=0 with src1 requesting -> src1 never granted.
REQ-036 Reset mid-packet: rst_i asserted during PAYLOAD with counter 5 -> next cycle busy_o=0, noc_tx_o=0, grant_o=0.
